// File: rtl/switch_debounce8.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce8
// Brief    : Synchronise and debounce WIDTH data switches plus an enable
//            switch; emit clean levels, a change strobe and a settled flag.
// Revision : 1.0 - initial release
// ============================================================================
module switch_debounce8 #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] sw_o,
    output logic             en_o,
    output logic             change_o,
    output logic             stable_o
);

    localparam int              c_n       = WIDTH + 1;
    localparam int              c_cw      = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cw-1:0] c_cnt_max = c_cw'(STABLE_CYCLES - 1);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);

    logic [c_n-1:0] w_raw;
    logic [c_n-1:0] r_sync [SYNC_STAGES];
    logic [c_n-1:0] w_s;
    logic [c_n-1:0] r_deb;
    logic [c_n-1:0] w_update;
    logic           r_change;

    // Enable rides as the top channel so all channels share one datapath.
    assign w_raw = {en_i, sw_i};
    assign w_s   = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    for (genvar g = 0; g < c_n; g++) begin : g_chan
        logic [c_cw-1:0] r_cnt;

        assign w_update[g] = (w_s[g] != r_deb[g]) && (r_cnt == c_cnt_max);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_s[g] == r_deb[g] || w_update[g]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    // A channel that completes its count flips its debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb    <= '0;
            r_change <= 1'b0;
        end else begin
            r_deb    <= r_deb ^ w_update;
            r_change <= |w_update;
        end
    end

    assign sw_o     = r_deb[WIDTH-1:0];
    assign en_o     = r_deb[WIDTH];
    assign change_o = r_change;
    assign stable_o = (w_s == r_deb);

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce8.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debounce8
// Brief    : Directed, self-checking bench for switch_debounce8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debounce8;

    typedef struct {
        logic [7:0] sw;
        logic       en;
        logic [7:0] exp_sw;
        logic       exp_en;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] sw_i;
    logic       en_i;
    logic [7:0] sw_o;
    logic       en_o;
    logic       change_o;
    logic       stable_o;

    int n_checks;
    int n_errors;

    switch_debounce8 #(
        .WIDTH        (8),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_i    (sw_i),
        .en_i    (en_i),
        .sw_o    (sw_o),
        .en_o    (en_o),
        .change_o(change_o),
        .stable_o(stable_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Returns 1 ns after a rising edge, so inputs set next land before the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs were just changed; outputs must hold for 17 edges and flip on edge 18.
    task automatic await_update(input logic [7:0] old_sw, input logic old_en,
                                input logic [7:0] new_sw, input logic new_en,
                                input string tag);
        int bad;
        bad = 0;
        repeat (17) begin
            tick();
            if (sw_o !== old_sw || en_o !== old_en || change_o !== 1'b0) bad++;
        end
        chk({tag, "_hold"}, bad, 0);
        tick();
        chk({tag, "_sw18"}, {24'd0, sw_o}, {24'd0, new_sw});
        chk({tag, "_en18"}, {31'd0, en_o}, {31'd0, new_en});
        chk({tag, "_chg18"}, {31'd0, change_o}, 32'd1);
        tick();
        chk({tag, "_chg19"}, {31'd0, change_o}, 32'd0);
        chk({tag, "_stable19"}, {31'd0, stable_o}, 32'd1);
        chk({tag, "_sw19"}, {24'd0, sw_o}, {24'd0, new_sw});
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0] prev_sw;
        logic       prev_en;
        int         bad;
        int         n_pulse;
        int         pulse_edge[2];
        logic [7:0] pulse_sw[2];

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{sw: 8'hFF, en: 1'b1, exp_sw: 8'hFF, exp_en: 1'b1};
        vecs[1] = '{sw: 8'h00, en: 1'b0, exp_sw: 8'h00, exp_en: 1'b0};
        vecs[2] = '{sw: 8'h00, en: 1'b1, exp_sw: 8'h00, exp_en: 1'b1};
        vecs[3] = '{sw: 8'h5A, en: 1'b1, exp_sw: 8'h5A, exp_en: 1'b1};
        vecs[4] = '{sw: 8'hA5, en: 1'b0, exp_sw: 8'hA5, exp_en: 1'b0};
        vecs[5] = '{sw: 8'h00, en: 1'b0, exp_sw: 8'h00, exp_en: 1'b0};

        // Reset held with all switches high: outputs stay cleared.
        rst  = 1'b1;
        sw_i = 8'hFF;
        en_i = 1'b1;
        #2;
        chk("rst_async_sw", {24'd0, sw_o}, 32'd0);
        repeat (3) tick();
        chk("rst_sw", {24'd0, sw_o}, 32'd0);
        chk("rst_en", {31'd0, en_o}, 32'd0);
        chk("rst_chg", {31'd0, change_o}, 32'd0);
        rst = 1'b0;

        prev_sw = 8'h00;
        prev_en = 1'b0;
        for (int v = 0; v < 6; v++) begin
            sw_i = vecs[v].sw;
            en_i = vecs[v].en;
            await_update(prev_sw, prev_en, vecs[v].exp_sw, vecs[v].exp_en, $sformatf("vec%0d", v));
            prev_sw = vecs[v].exp_sw;
            prev_en = vecs[v].exp_en;
        end

        // Short pulse on bit 3 (5 cycles) is rejected.
        sw_i = 8'h08;
        repeat (3) tick();
        chk("glitch_unstable", {31'd0, stable_o}, 32'd0);
        repeat (2) tick();
        sw_i = 8'h00;
        bad  = 0;
        repeat (30) begin
            tick();
            if (sw_o !== 8'h00 || change_o !== 1'b0) bad++;
        end
        chk("glitch_reject", bad, 0);
        chk("glitch_stable", {31'd0, stable_o}, 32'd1);

        // Bounce 1/0/1 with 3-cycle gaps, then hold high.
        sw_i = 8'h08;
        repeat (3) tick();
        sw_i = 8'h00;
        repeat (3) tick();
        sw_i = 8'h08;
        await_update(8'h00, 1'b0, 8'h08, 1'b0, "bounce");

        // Two bits rise together, then fall 4 cycles apart.
        sw_i = 8'h81;
        await_update(8'h08, 1'b0, 8'h81, 1'b0, "pair");
        sw_i    = 8'h01;
        n_pulse = 0;
        pulse_edge[0] = 0; pulse_edge[1] = 0;
        pulse_sw[0]   = 8'hXX; pulse_sw[1] = 8'hXX;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (change_o === 1'b1) begin
                if (n_pulse < 2) begin
                    pulse_edge[n_pulse] = e;
                    pulse_sw[n_pulse]   = sw_o;
                end
                n_pulse++;
            end
            if (e == 4) sw_i = 8'h00;
        end
        chk("split_npulse", n_pulse, 2);
        chk("split_edge0", pulse_edge[0], 18);
        chk("split_edge1", pulse_edge[1], 22);
        chk("split_sw0", {24'd0, pulse_sw[0]}, 32'h01);
        chk("split_sw1", {24'd0, pulse_sw[1]}, 32'h00);

        // Reset in the middle of a count restarts the full latency.
        sw_i = 8'h10;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        chk("midrst_sw", {24'd0, sw_o}, 32'd0);
        chk("midrst_chg", {31'd0, change_o}, 32'd0);
        tick();
        rst = 1'b0;
        await_update(8'h00, 1'b0, 8'h10, 1'b0, "midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
